// File: rtl/serv_rf_ram_adapter.sv
// serv_rf_ram_adapter
//   Bridges SERV's bit-serial register file ports onto a simple dual-port
//   RAM of `width`-bit words. The RAM holds 32 GPRs followed by `csr_regs`
//   CSR slots, each 32 bits, at address {reg[5:0], word}.
//
//   Write side: two serial write ports share one bit counter (wcnt). Each
//   port assembles a word in a shift buffer; on word completion port 0 is
//   written in the next cycle and port 1 in the cycle after that.
//   Read side: i_rreq (accepted only while idle) streams both registers
//   out LSB first, o_ready marking bit 0. Words are fetched one per cycle,
//   port 0 one cycle ahead of port 1, each just in time for its first bit.
//
//   Ports:
//     clk, i_rst_n              clock, synchronous active-low reset
//     i_wreg*/i_wen*/i_wdata*   serial write ports 0/1
//     i_rreq, i_rreg*           read request and register addresses
//     o_ready, o_rdata*         bit-0 marker and serial read data
//     o_waddr/o_wdata/o_wen     RAM write port
//     o_raddr/o_ren/i_rdata     RAM read port (one-cycle read latency)
//
//   Build option: define SERV_RF_RAM_X0_MASK_EN to make register 0 read as
//   zero and never be written.
module serv_rf_ram_adapter #(
  parameter  int width    = 8,
  parameter  int csr_regs = 4,
  localparam int depth    = (32 + csr_regs) * 32 / width,
  localparam int aw       = $clog2(depth)
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_rreq,
  output logic             o_ready,
  input  logic [5:0]       i_wreg0,
  input  logic [5:0]       i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic             i_wdata0,
  input  logic             i_wdata1,
  input  logic [5:0]       i_rreg0,
  input  logic [5:0]       i_rreg1,
  output logic             o_rdata0,
  output logic             o_rdata1,
  output logic [aw-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [aw-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata
);

`ifdef SERV_RF_RAM_X0_MASK_EN
  localparam bit X0_MASK = 1'b1;
`else
  localparam bit X0_MASK = 1'b0;
`endif

  localparam int lw = $clog2(width);

  function automatic logic [aw-1:0] ram_addr(input logic [5:0] r, input logic [4:0] idx);
    ram_addr = aw'((32'(r) << (5 - lw)) | 32'(idx >> lw));
  endfunction

  // ---------------- write side ----------------
  logic [4:0]       wcnt;
  logic [width-2:0] wbuf0, wbuf1;   // last bit of a word comes straight from the input
  logic             pend1;
  logic [aw-1:0]    pend_addr;
  logic [width-1:0] pend_data;

  logic             any_wen, wdone, wkeep0, wkeep1;
  logic [width-1:0] word0, word1;

  assign any_wen = i_wen0 | i_wen1;
  assign wdone   = any_wen && ((wcnt & 5'(width - 1)) == 5'(width - 1));
  assign word0   = {i_wdata0, wbuf0};
  assign word1   = {i_wdata1, wbuf1};
  assign wkeep0  = !X0_MASK || (i_wreg0 != 6'd0);
  assign wkeep1  = !X0_MASK || (i_wreg1 != 6'd0);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      wcnt      <= '0;
      wbuf0     <= '0;
      wbuf1     <= '0;
      pend1     <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      o_wen     <= 1'b0;
      o_waddr   <= '0;
      o_wdata   <= '0;
    end else begin
      if (any_wen) wcnt  <= wcnt + 5'd1;
      if (i_wen0)  wbuf0 <= word0[width-1:1];
      if (i_wen1)  wbuf1 <= word1[width-1:1];
      o_wen <= 1'b0;
      pend1 <= 1'b0;
      // Both addresses are captured here; port 1 waits one cycle in pend_*.
      // A completion and a pending port-1 write can never coincide (width >= 4).
      if (wdone) begin
        o_wen     <= i_wen0 & wkeep0;
        o_waddr   <= ram_addr(i_wreg0, wcnt);
        o_wdata   <= word0;
        pend1     <= i_wen1 & wkeep1;
        pend_addr <= ram_addr(i_wreg1, wcnt);
        pend_data <= word1;
      end else if (pend1) begin
        o_wen   <= 1'b1;
        o_waddr <= pend_addr;
        o_wdata <= pend_data;
      end
    end
  end

  // ---------------- read side ----------------
  // rcnt = cycles since the accepted request; busy covers T+1..T+34.
  logic             busy, ren_port, ld0, ld1;
  logic [5:0]       rcnt, rreg0_q, rreg1_q;
  logic [width-1:0] rbuf0, rbuf1;

  logic       start, issue, is_p1, out_act, rkeep0, rkeep1;
  logic [5:0] n, rsel;

  assign start = i_rreq & ~busy;
  assign n     = start ? 6'd0 : rcnt;
  // Port 0 word k is fetched at offset k*width+1, port 1 at k*width+2, so
  // the data lands exactly when the first bit of that word is due.
  assign issue = (start | busy) && (n < 6'd32) && ((n & 6'(width - 1)) <= 6'd1);
  assign is_p1 = n[0];
  assign rsel  = is_p1 ? rreg1_q : (start ? i_rreg0 : rreg0_q);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      busy     <= 1'b0;
      rcnt     <= '0;
      rreg0_q  <= '0;
      rreg1_q  <= '0;
      ren_port <= 1'b0;
      ld0      <= 1'b0;
      ld1      <= 1'b0;
      rbuf0    <= '0;
      rbuf1    <= '0;
      o_ren    <= 1'b0;
      o_raddr  <= '0;
      o_ready  <= 1'b0;
    end else begin
      o_ren <= issue;
      if (issue) begin
        o_raddr  <= ram_addr(rsel, n[4:0]);
        ren_port <= is_p1;
      end
      ld0 <= o_ren & ~ren_port;
      ld1 <= o_ren & ren_port;
      if (start) begin
        busy    <= 1'b1;
        rcnt    <= 6'd1;
        rreg0_q <= i_rreg0;
        rreg1_q <= i_rreg1;
      end else if (busy) begin
        rcnt <= rcnt + 6'd1;
        if (rcnt == 6'd34) busy <= 1'b0;
      end
      o_ready <= busy && (rcnt == 6'd2);
      rbuf0   <= ld0 ? i_rdata : rbuf0 >> 1;
      rbuf1   <= ld1 ? i_rdata >> 1 : rbuf1 >> 1;
    end
  end

  assign out_act = busy && (rcnt >= 6'd3);
  assign rkeep0  = !X0_MASK || (rreg0_q != 6'd0);
  assign rkeep1  = !X0_MASK || (rreg1_q != 6'd0);

  // Port 1 data arrives in the same cycle its first bit is due, so that bit
  // passes straight from i_rdata; the rest come from rbuf1.
  assign o_rdata0 = out_act & rkeep0 & rbuf0[0];
  assign o_rdata1 = out_act & rkeep1 & (ld1 ? i_rdata[0] : rbuf1[0]);

endmodule

// File: tb/tb_serv_rf_ram_adapter.sv
// Testbench for serv_rf_ram_adapter: RAM environment, write-event monitor,
// and a whole-register reference model checked with immediate assertions.
module tb_serv_rf_ram_adapter;
  localparam int W     = 8;
  localparam int CSR   = 4;
  localparam int DEPTH = (32 + CSR) * 32 / W;
  localparam int AW    = $clog2(DEPTH);
  localparam int NW    = 32 / W;
`ifdef SERV_RF_RAM_X0_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rst_n, i_rreq, o_ready;
  logic [5:0]    i_wreg0, i_wreg1, i_rreg0, i_rreg1;
  logic          i_wen0, i_wen1, i_wdata0, i_wdata1;
  logic          o_rdata0, o_rdata1, o_wen, o_ren;
  logic [AW-1:0] o_waddr, o_raddr;
  logic [W-1:0]  o_wdata, i_rdata;

  serv_rf_ram_adapter #(.width(W), .csr_regs(CSR)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_rreq(i_rreq), .o_ready(o_ready),
    .i_wreg0(i_wreg0), .i_wreg1(i_wreg1), .i_wen0(i_wen0), .i_wen1(i_wen1),
    .i_wdata0(i_wdata0), .i_wdata1(i_wdata1), .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
    .o_rdata0(o_rdata0), .o_rdata1(o_rdata1), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_wen(o_wen), .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM environment with one-cycle read latency
  logic [W-1:0] mem [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (o_wen) mem[o_waddr] <= o_wdata;
    if (o_ren) i_rdata <= mem[o_raddr];
  end

  typedef struct { logic [AW-1:0] a; logic [W-1:0] d; int c; } wr_t;
  wr_t wq[$];
  always @(negedge clk) if (o_wen === 1'b1) wq.push_back(wr_t'{o_waddr, o_wdata, cyc});

  int checks = 0, errors = 0;
  logic [31:0] model [64];
  int ws_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] eaddr(input int r, input int k);
    return AW'(r * NW + k);
  endfunction

  // Stream one 32-bit value per port; the write address is only valid in
  // completion cycles and is garbage elsewhere.
  task automatic wr(input int r0, input logic [31:0] v0, input bit e0,
                    input int r1, input logic [31:0] v1, input bit e1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) ws_start = cyc;
      i_wen0 = e0; i_wen1 = e1;
      i_wdata0 = v0[i]; i_wdata1 = v1[i];
      i_wreg0 = (i % W == W - 1) ? 6'(r0) : 6'($urandom);
      i_wreg1 = (i % W == W - 1) ? 6'(r1) : 6'($urandom);
    end
    @(negedge clk);
    i_wen0 = 0; i_wen1 = 0; i_wreg0 = 6'($urandom); i_wreg1 = 6'($urandom);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_wr(input int r0, input logic [31:0] v0, input bit e0,
                        input int r1, input logic [31:0] v1, input bit e1, input string tag);
    wr_t ex[$];
    for (int k = 0; k < NW; k++) begin
      if (e0 && !(MASK && r0 == 0)) ex.push_back(wr_t'{eaddr(r0, k), v0[k*W +: W], ws_start + k*W + W});
      if (e1 && !(MASK && r1 == 0)) ex.push_back(wr_t'{eaddr(r1, k), v1[k*W +: W], ws_start + k*W + W + 1});
    end
    chk($sformatf("%s nwrites", tag), wq.size(), ex.size());
    for (int j = 0; j < ex.size() && j < wq.size(); j++) begin
      chk($sformatf("%s w%0d addr", tag, j), 32'(wq[j].a), 32'(ex[j].a));
      chk($sformatf("%s w%0d data", tag, j), 32'(wq[j].d), 32'(ex[j].d));
      chk($sformatf("%s w%0d cycle", tag, j), wq[j].c - ws_start, ex[j].c - ws_start);
    end
  endtask

  function automatic void upd(input int r, input logic [31:0] v, input bit e);
    if (e && !(MASK && r == 0)) model[r] = v;
  endfunction

  task automatic rd(input int r0, input int r1, input bit dbl, input string tag);
    logic [31:0] b0 = '0, b1 = '0, x0, x1;
    int rdy_n = 0, rdy_at = -1, ren_n = 0;
    x0 = (MASK && r0 == 0) ? 32'h0 : model[r0];
    x1 = (MASK && r1 == 0) ? 32'h0 : model[r1];
    @(negedge clk);
    i_rreg0 = 6'(r0); i_rreg1 = 6'(r1); i_rreq = 1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (o_ready) begin rdy_n++; rdy_at = c; end
      if (o_ren) ren_n++;
      if (c >= 3 && c <= 34) begin b0[c-3] = o_rdata0; b1[c-3] = o_rdata1; end
      if (c >= 35) chk($sformatf("%s idle rdata c%0d", tag, c), {o_rdata1, o_rdata0}, 0);
      i_rreq  = dbl && (c == 10);
      i_rreg0 = 6'($urandom); i_rreg1 = 6'($urandom);
    end
    i_rreq = 0;
    chk($sformatf("%s ready pulses", tag), rdy_n, 1);
    chk($sformatf("%s ready offset", tag), rdy_at, 3);
    chk($sformatf("%s ram reads", tag), ren_n, 2 * NW);
    chk($sformatf("%s data0", tag), b0, x0);
    chk($sformatf("%s data1", tag), b1, x1);
  endtask

  initial begin
    int a, b, c, d;
    logic [31:0] va, vb, v;
    bit ea, eb;
    for (int i = 0; i < 64; i++) model[i] = '0;
    i_rst_n = 0; i_rreq = 0; i_wen0 = 0; i_wen1 = 0; i_wdata0 = 0; i_wdata1 = 0;
    i_wreg0 = 0; i_wreg1 = 0; i_rreg0 = 0; i_rreg1 = 0;
    repeat (3) @(negedge clk);
    i_rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle c%0d", i), {o_ready, o_wen, o_ren, o_rdata0, o_rdata1}, 0);
    end

    // two ports, GPR 5 and CSR slot 34
    wq.delete();
    wr(5, 32'hDEADBEEF, 1, 34, 32'h12345678, 1);
    chk_wr(5, 32'hDEADBEEF, 1, 34, 32'h12345678, 1, "wr5_34");
    upd(5, 32'hDEADBEEF, 1); upd(34, 32'h12345678, 1);
    rd(5, 34, 0, "rd5_34");
    rd(5, 34, 1, "rd_dbl");

    // register 0
    wq.delete();
    wr(0, 32'hFFFFFFFF, 1, 0, 32'h0, 0);
    chk_wr(0, 32'hFFFFFFFF, 1, 0, 32'h0, 0, "wr_x0");
    upd(0, 32'hFFFFFFFF, 1);
    rd(0, 0, 0, "rd_x0");

    // reset at bit 12 of a stream: only word 0 may reach the RAM
    v = $urandom;
    wq.delete();
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i == 0) ws_start = cyc;
      i_wreg0 = 6'd7; i_wen0 = 1; i_wdata0 = v[i];
      if (i == 12) i_rst_n = 0;
    end
    @(negedge clk);
    chk("post-reset idle", {o_ready, o_wen, o_ren, o_rdata0, o_rdata1}, 0);
    i_rst_n = 1; i_wen0 = 0;
    repeat (10) @(negedge clk);
    chk("abort nwrites", wq.size(), 1);
    if (wq.size() > 0) begin
      chk("abort addr", 32'(wq[0].a), 32'(eaddr(7, 0)));
      chk("abort data", 32'(wq[0].d), 32'(v[W-1:0]));
    end
    model[7][W-1:0] = v[W-1:0];
    va = $urandom; vb = $urandom;
    wq.delete();
    wr(7, va, 1, 9, vb, 1);
    chk_wr(7, va, 1, 9, vb, 1, "wr_after_rst");
    upd(7, va, 1); upd(9, vb, 1);
    rd(7, 9, 0, "rd7_9");

    // random writes overlapped with reads of other registers
    a = 1; b = 2;
    for (int it = 0; it < 6; it++) begin
      a = $urandom_range(1, 31 + CSR);
      do b = $urandom_range(1, 31 + CSR); while (b == a);
      do c = $urandom_range(1, 31 + CSR); while (c == a || c == b);
      do d = $urandom_range(1, 31 + CSR); while (d == a || d == b);
      va = $urandom; vb = $urandom;
      ea = 1'($urandom_range(0, 1)); eb = 1'($urandom_range(0, 1));
      if (!ea && !eb) eb = 1;
      wq.delete();
      fork
        wr(a, va, ea, b, vb, eb);
        rd(c, d, 0, $sformatf("rnd%0d rd", it));
      join
      chk_wr(a, va, ea, b, vb, eb, $sformatf("rnd%0d wr", it));
      upd(a, va, ea); upd(b, vb, eb);
    end
    rd(a, b, 0, "rd_last");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serv_rf_ram_adapter.md
SERV_RF_RAM_ADAPTER -- requirements
Module: serv_rf_ram_adapter

Interface
REQ-001 SHALL have parameter width, default 8, meaning RAM word width; legal values 4, 8, 16, 32.
REQ-002 SHALL have parameter csr_regs, default 4, meaning CSR slots placed after the 32 GPRs.
REQ-003 SHALL derive depth = (32+csr_regs)*32/width and aw = clog2(depth); these are not overridable.
REQ-004 SHALL have ports, as name, direction, width, meaning:
- clk, in, 1: sole clock.
- i_rst_n, in, 1: synchronous active-low reset.
- i_rreq, in, 1: start read of both ports.
- o_ready, out, 1: one-cycle pulse marking bit 0 valid.
- i_wreg0 and i_wreg1, in, 6: write register addresses.
- i_wen0 and i_wen1, in, 1: per-bit write enables.
- i_wdata0 and i_wdata1, in, 1: serial write bits, LSB first.
- i_rreg0 and i_rreg1, in, 6: read register addresses.
- o_rdata0 and o_rdata1, out, 1: serial read bits, LSB first.
- o_waddr, out, aw: RAM write address.
- o_wdata, out, width: RAM write data.
- o_wen, out, 1: RAM write enable.
- o_raddr, out, aw: RAM read address.
- o_ren, out, 1: RAM read enable.
- i_rdata, in, width: RAM read data, one-cycle latency after o_ren.

Function
REQ-005 SHALL form the RAM address as {reg[5:0], word}, with word = bit index >> log2(width).
REQ-006 SHALL keep a 5-bit write counter wcnt that increments in every cycle where i_wen0|i_wen1 is 1 and wraps 31->0.
REQ-007 SHALL shift i_wdata0/i_wdata1 into per-port width-bit buffers in each cycle where the respective enable is 1.
REQ-008 SHALL complete a word when wcnt[log2(width)-1:0]==width-1.
REQ-009 SHALL, on word completion, drive o_wen=1 with port-0 data in cycle C+1 and port-1 data in cycle C+2, where C is the completion cycle.
REQ-010 SHALL write only the ports whose enable was 1 in cycle C.
REQ-011 SHALL capture i_wreg0/i_wreg1 at word completion, so a later address change does not corrupt the pending write.
REQ-012 SHALL accept i_rreq only while idle; i_rreq while busy SHALL be ignored.
REQ-013 SHALL, for i_rreq in cycle T:
- read word 0 of rreg0 at T+1 and word 0 of rreg1 at T+2;
- drive o_ready=1 in T+3 only;
- present bit i on o_rdata0/1 in cycle T+3+i for i=0..31;
- return to idle after T+34.
REQ-014 SHALL prefetch each following word early enough that the o_rdata streams never stall.
REQ-015 SHALL issue at most one RAM read per cycle, and SHALL NOT re-read a word already held.
REQ-016 SHALL sample the i_rreg0/i_rreg1 addresses at T and ignore later changes to them.
REQ-017 SHALL keep the RAM write and read ports independent; reads SHALL return the RAM content as of the read cycle, with no bypass.
REQ-018 SHALL let an i_rreq coinciding with an ongoing write proceed without delaying either.
REQ-019 SHALL drive o_rdata0/1 to 0 while idle.

Reset
REQ-020 SHALL, while i_rst_n=0 at a clk edge, clear: o_ready, o_wen, o_ren, o_waddr, o_raddr, o_wdata, o_rdata0, o_rdata1, wcnt, the read counter and all shift buffers.
REQ-021 SHALL treat a reset during a read or write as an abort: pending words are dropped, no RAM write occurs after reset, and the block is idle in the first cycle after reset.
REQ-022 SHALL NOT initialise RAM contents.

Configuration
REQ-023 SHALL support the macro SERV_RF_RAM_X0_MASK_EN.
REQ-024 SHALL, when SERV_RF_RAM_X0_MASK_EN is defined, force o_rdata to 0 for any read with rreg==6'd0 and suppress o_wen for writes with wreg==6'd0.
REQ-025 SHALL, when SERV_RF_RAM_X0_MASK_EN is undefined, treat register 0 like any other address.

Verification
REQ-026 SHALL cover: reset, then idle for 5 cycles -> o_ready=0, o_wen=0, o_ren=0, o_rdata0=o_rdata1=0.
REQ-027 SHALL cover: with width=8, stream 0xDEADBEEF to reg 5 on port 0 and 0x12345678 to CSR slot 34 on port 1 -> 4+4 RAM writes with data EF,BE,AD,DE at address {5,0..3} and 78,56,34,12 at {34,0..3}, each port-1 write one cycle after its port-0 write.
REQ-028 SHALL cover: after REQ-027, i_rreq with rreg0=5, rreg1=34 -> o_ready at T+3, then 32 bits reconstruct 0xDEADBEEF and 0x12345678.
REQ-029 SHALL cover: with the macro defined, write 0xFFFFFFFF to reg 0 then read reg 0 -> no o_wen pulse and 32 zero bits; without the macro -> 4 writes occur and 0xFFFFFFFF is read back.
REQ-030 SHALL cover: i_rst_n=0 at bit 12 of a write stream -> no further o_wen, wcnt=0, and a fresh 32-bit write afterwards lands correctly.
REQ-031 SHALL cover: a second i_rreq at T+10 -> ignored, with a single o_ready pulse and an unchanged stream.
